checksum_inserter: RTL and testbench
====================================

# checksum_inserter

Parametrised AXI4-Stream checksum inserter for the streaming datapath between the host-facing input stream and the user/network output stream. Forwards every input beat through a one-deep registered output stage, accumulates a modular lane-sum of the keep-masked payload, and appends one checksum beat after every `group_len` accepted beats or after a `tlast` beat, whichever comes first. Full ready/valid backpressure on both sides; group length is configurable at run time up to a compile-time maximum.

## Interface
- `DATA_W`, 512, stream data width in bits; multiple of `CSUM_W`
- `ID_W`, 6, stream TID width
- `CSUM_W`, 32, checksum/lane width in bits; multiple of 8
- `GROUP_MAX`, 4, maximum beats per checksum group (>= 1)

- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `group_len`  in  clog2(GROUP_MAX+1)  beats per group; sampled on the first accepted beat of each group
- `inp_data`  in  DATA_W  input payload
- `inp_valid`  in  1  input beat valid
- `inp_ready`  out  1  input beat ready
- `inp_keep`  in  DATA_W/8  byte enables
- `inp_id`  in  ID_W  TID
- `inp_last`  in  1  TLAST
- `out`  out  DATA_W  output payload
- `out_valid`  out  1  output beat valid
- `out_ready`  in  1  output beat ready
- `out_keep`  out  DATA_W/8  output byte enables
- `out_id`  out  ID_W  output TID
- `out_last`  out  1  output TLAST

## Operation
- States: PASS, CSUM. Reset state PASS.
- Output register "free" = `!out_valid || out_ready`.
- `inp_ready` = free && state==PASS; 0 while `reset` low.
- Beat sum: zero every byte with keep=0, split into DATA_W/CSUM_W lanes, add all lanes modulo 2^CSUM_W.
- PASS, on accept (`inp_valid && inp_ready`):
  - out regs <= inp_data/keep/id; `out_last` <= 0 (data beats never carry TLAST); `out_valid` <= 1.
  - If first beat of group: effective length L = clamp(`group_len`, 1, GROUP_MAX) latched; 0 treated as 1.
  - Group closes if `inp_last` or beat count == L-1: csum_hold <= acc + beat sum; id_hold <= inp_id; last_hold <= inp_last; acc <= 0; count <= 0; state <= CSUM.
  - Otherwise acc <= acc + beat sum; count <= count+1.
- PASS, no accept: if `out_ready` then `out_valid` <= 0; else hold.
- CSUM, when free: `out` <= csum_hold zero-extended to DATA_W (checksum in bits CSUM_W-1:0); `out_keep` <= low CSUM_W/8 bits set; `out_id` <= id_hold; `out_last` <= last_hold; `out_valid` <= 1; state <= PASS.
- CSUM, not free: hold everything.
- Output regs held stable while `out_valid && !out_ready` (AXI stability).
- `group_len` changes mid-group have no effect until the next group.

## Timing
- Reset (async assert): state PASS, acc 0, count 0, holds 0; `out`, `out_valid`, `out_keep`, `out_id`, `out_last` all 0; `inp_ready` 0. Reset mid-group discards the partial group and its checksum; no checksum beat is emitted for it.
- Latency: input beat accepted at edge N appears on outputs after edge N.
- Checksum beat appears on outputs after the edge that follows the closing-beat accept, provided the output register is free.
- Throughput with `out_ready`=1: a group of L beats occupies L+1 cycles; `inp_ready` low exactly 1 cycle per group.
- Simultaneous `inp_last` and count==L-1: a single checksum beat is emitted.
- Accumulator wraps modulo 2^CSUM_W with no carry fold.
- No combinational path from `inp_valid` to `out_valid`; `inp_ready` depends combinationally on `out_ready`.

## Test plan
- `group_len`=4, 4 beats of all lanes 0x00000001, keep all-ones, id 5, last only on beat 4 -> 4 data beats (`out_last`=0), then checksum beat `out`=0x40, `out_keep`=0xF, `out_id`=5, `out_last`=1.
- `group_len`=4, single beat lanes 0x00000003, `inp_last`=1, id 2 -> data beat, then checksum 0x30 with `out_last`=1, `out_id`=2; count restarts at 0.
- `group_len`=2, 6 beats, no last -> 3 checksum beats each `out_last`=0; lane 0 = 0xFFFFFFFF in beat 1 and 0x00000002 in beat 2, all other lanes 0 -> checksum 0x00000001 (wrap).
- Keep masking: lane 0 = 0xAABBCCDD, keep=0x1, other lanes 0 -> checksum 0x000000DD.
- Backpressure: `out_ready` toggled 1-0-0-1 random pattern -> no beat lost or duplicated, outputs stable while stalled, `inp_ready`=0 whenever the output register holds an unaccepted beat.
- Reset asserted after beat 2 of a 4-beat group -> all outputs 0 immediately; after release a fresh 4-beat group yields a checksum over only the new beats.

Source files
------------

// File: rtl/checksum_inserter.sv
// checksum_inserter: forwards AXI4-Stream beats through a one-deep output
// register and appends a modular lane-sum checksum beat after every group
// of group_len beats, or after a TLAST beat, whichever comes first.
module checksum_inserter #(
  parameter int DATA_W    = 512,
  parameter int ID_W      = 6,
  parameter int CSUM_W    = 32,
  parameter int GROUP_MAX = 4,
  localparam int KEEP_W   = DATA_W / 8,
  localparam int GL_W     = $clog2(GROUP_MAX + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [GL_W-1:0]   group_len,
  input  logic [DATA_W-1:0] inp_data,
  input  logic              inp_valid,
  output logic              inp_ready,
  input  logic [KEEP_W-1:0] inp_keep,
  input  logic [ID_W-1:0]   inp_id,
  input  logic              inp_last,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [KEEP_W-1:0] out_keep,
  output logic [ID_W-1:0]   out_id,
  output logic              out_last
);

  localparam int LANES = DATA_W / CSUM_W;

  typedef enum logic [0:0] {
    PASS = 1'b0,
    CSUM = 1'b1
  } state_t;

  // Keep-masked beat sum: zero disabled bytes, then add all lanes mod 2^CSUM_W.
  function automatic logic [CSUM_W-1:0] beat_sum(input logic [DATA_W-1:0] d,
                                                 input logic [KEEP_W-1:0] k);
    logic [DATA_W-1:0] m;
    logic [CSUM_W-1:0] s;
    for (int b = 0; b < KEEP_W; b++) begin
      m[b*8 +: 8] = k[b] ? d[b*8 +: 8] : 8'h00;
    end
    s = {CSUM_W{1'b0}};
    for (int l = 0; l < LANES; l++) begin
      s = s + m[l*CSUM_W +: CSUM_W];
    end
    return s;
  endfunction

  // Effective group length: 0 behaves as 1, anything above GROUP_MAX saturates.
  function automatic logic [GL_W-1:0] clamp_len(input logic [GL_W-1:0] gl);
    if (gl == {GL_W{1'b0}}) begin
      return GL_W'(1);
    end else if (gl > GL_W'(GROUP_MAX)) begin
      return GL_W'(GROUP_MAX);
    end else begin
      return gl;
    end
  endfunction

  state_t            state_r, state_nxt;
  logic [CSUM_W-1:0] acc_r, acc_nxt;
  logic [GL_W-1:0]   cnt_r, cnt_nxt;
  logic [GL_W-1:0]   len_r, len_nxt;
  logic [CSUM_W-1:0] csum_hold_r, csum_hold_nxt;
  logic [ID_W-1:0]   id_hold_r, id_hold_nxt;
  logic              last_hold_r, last_hold_nxt;
  logic [DATA_W-1:0] out_r, out_nxt;
  logic              out_valid_r, out_valid_nxt;
  logic [KEEP_W-1:0] out_keep_r, out_keep_nxt;
  logic [ID_W-1:0]   out_id_r, out_id_nxt;
  logic              out_last_r, out_last_nxt;

  logic              free_s;
  logic              accept_s;
  logic [GL_W-1:0]   eff_len_s;
  logic [CSUM_W-1:0] sum_s;

  assign free_s    = !out_valid_r || out_ready;
  assign inp_ready = free_s && (state_r == PASS) && reset;
  assign accept_s  = inp_valid && inp_ready;
  assign sum_s     = acc_r + beat_sum(inp_data, inp_keep);
  // First beat of a group uses the live group_len; later beats the latched one.
  assign eff_len_s = (cnt_r == {GL_W{1'b0}}) ? clamp_len(group_len) : len_r;

  assign out       = out_r;
  assign out_valid = out_valid_r;
  assign out_keep  = out_keep_r;
  assign out_id    = out_id_r;
  assign out_last  = out_last_r;

  // Next-state and output-register logic for the PASS/CSUM sequencer.
  always_comb begin
    state_nxt     = state_r;
    acc_nxt       = acc_r;
    cnt_nxt       = cnt_r;
    len_nxt       = len_r;
    csum_hold_nxt = csum_hold_r;
    id_hold_nxt   = id_hold_r;
    last_hold_nxt = last_hold_r;
    out_nxt       = out_r;
    out_valid_nxt = out_valid_r;
    out_keep_nxt  = out_keep_r;
    out_id_nxt    = out_id_r;
    out_last_nxt  = out_last_r;
    case (state_r)
      PASS: begin
        if (accept_s) begin
          out_nxt       = inp_data;
          out_keep_nxt  = inp_keep;
          out_id_nxt    = inp_id;
          out_last_nxt  = 1'b0;
          out_valid_nxt = 1'b1;
          if (cnt_r == {GL_W{1'b0}}) begin
            len_nxt = eff_len_s;
          end else begin
            len_nxt = len_r;
          end
          if (inp_last || (cnt_r == (eff_len_s - GL_W'(1)))) begin
            csum_hold_nxt = sum_s;
            id_hold_nxt   = inp_id;
            last_hold_nxt = inp_last;
            acc_nxt       = {CSUM_W{1'b0}};
            cnt_nxt       = {GL_W{1'b0}};
            state_nxt     = CSUM;
          end else begin
            acc_nxt = sum_s;
            cnt_nxt = cnt_r + GL_W'(1);
          end
        end else if (out_ready) begin
          out_valid_nxt = 1'b0;
        end else begin
          out_valid_nxt = out_valid_r;
        end
      end
      CSUM: begin
        if (free_s) begin
          out_nxt       = DATA_W'(csum_hold_r);
          out_keep_nxt  = KEEP_W'({(CSUM_W/8){1'b1}});
          out_id_nxt    = id_hold_r;
          out_last_nxt  = last_hold_r;
          out_valid_nxt = 1'b1;
          state_nxt     = PASS;
        end else begin
          state_nxt = CSUM;
        end
      end
      default: begin
        state_nxt = PASS;
      end
    endcase
  end

  // State, accumulator and output registers; async reset discards any partial group.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= PASS;
      acc_r       <= {CSUM_W{1'b0}};
      cnt_r       <= {GL_W{1'b0}};
      len_r       <= {GL_W{1'b0}};
      csum_hold_r <= {CSUM_W{1'b0}};
      id_hold_r   <= {ID_W{1'b0}};
      last_hold_r <= 1'b0;
      out_r       <= {DATA_W{1'b0}};
      out_valid_r <= 1'b0;
      out_keep_r  <= {KEEP_W{1'b0}};
      out_id_r    <= {ID_W{1'b0}};
      out_last_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      acc_r       <= acc_nxt;
      cnt_r       <= cnt_nxt;
      len_r       <= len_nxt;
      csum_hold_r <= csum_hold_nxt;
      id_hold_r   <= id_hold_nxt;
      last_hold_r <= last_hold_nxt;
      out_r       <= out_nxt;
      out_valid_r <= out_valid_nxt;
      out_keep_r  <= out_keep_nxt;
      out_id_r    <= out_id_nxt;
      out_last_r  <= out_last_nxt;
    end
  end

endmodule

// File: tb/tb_checksum_inserter.sv
// Directed bench for checksum_inserter with a scoreboard queue fed by a
// reference model at every input accept and drained at every output transfer.
module tb_checksum_inserter;

  localparam int DATA_W = 512;
  localparam int ID_W   = 6;
  localparam int KEEP_W = DATA_W / 8;
  localparam int GL_W   = 3;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic [ID_W-1:0]   id;
    logic              last;
    logic              is_csum;
  } beat_t;

  logic              clock = 1'b0;
  logic              reset;
  logic [GL_W-1:0]   group_len;
  logic [DATA_W-1:0] inp_data;
  logic              inp_valid;
  logic              inp_ready;
  logic [KEEP_W-1:0] inp_keep;
  logic [ID_W-1:0]   inp_id;
  logic              inp_last;
  logic [DATA_W-1:0] out;
  logic              out_valid;
  logic              out_ready;
  logic [KEEP_W-1:0] out_keep;
  logic [ID_W-1:0]   out_id;
  logic              out_last;

  int    checks = 0;
  int    errors = 0;
  beat_t sb[$];
  logic  bp_en = 1'b0;

  logic [31:0] last_csum = 32'h0;
  logic        last_csum_last = 1'b0;
  logic [5:0]  last_csum_id = 6'h0;
  int          csum_cnt = 0;

  checksum_inserter dut (
    .clock(clock), .reset(reset), .group_len(group_len),
    .inp_data(inp_data), .inp_valid(inp_valid), .inp_ready(inp_ready),
    .inp_keep(inp_keep), .inp_id(inp_id), .inp_last(inp_last),
    .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .out_keep(out_keep), .out_id(out_id), .out_last(out_last)
  );

  initial forever #5 clock = ~clock;

  task automatic chk(input string tag, input logic [639:0] got, input logic [639:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference checksum: each enabled byte weighted by its position in its 32-bit lane.
  function automatic logic [31:0] ref_sum(input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k);
    logic [31:0] s = 32'h0;
    for (int b = 0; b < KEEP_W; b++) begin
      if (k[b]) s = s + (32'(d[b*8 +: 8]) << (8 * (b % 4)));
    end
    return s;
  endfunction

  function automatic int ref_len(input logic [GL_W-1:0] gl);
    if (gl == 3'd0) return 1;
    if (int'(gl) > 4) return 4;
    return int'(gl);
  endfunction

  // Output backpressure pattern, changed just after each rising edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor + reference model, sampled mid-cycle.
  initial begin
    logic [31:0] m_acc = 32'h0;
    int          m_cnt = 0;
    int          m_len = 1;
    logic        prev_stall = 1'b0;
    logic [583:0] saved = '0;
    beat_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        sb.delete();
        m_acc = 32'h0;
        m_cnt = 0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) chk("stall_stable", 640'({out, out_keep, out_id, out_last, out_valid}), 640'(saved));
        if (out_valid && !out_ready) chk("ready_while_stalled", 640'(inp_ready), 640'(0));
        if (out_valid && out_ready) begin
          checks++;
          assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_beat: observed data %0h expected none", out);
          end
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk(e.is_csum ? "csum_beat" : "data_beat",
                640'({out, out_keep, out_id, out_last}), 640'({e.data, e.keep, e.id, e.last}));
            if (e.is_csum) begin
              last_csum = out[31:0];
              last_csum_last = out_last;
              last_csum_id = out_id;
              csum_cnt++;
            end
          end
        end
        if (inp_valid && inp_ready) begin
          if (m_cnt == 0) m_len = ref_len(group_len);
          m_acc = m_acc + ref_sum(inp_data, inp_keep);
          e.data = inp_data; e.keep = inp_keep; e.id = inp_id; e.last = 1'b0; e.is_csum = 1'b0;
          sb.push_back(e);
          if (inp_last || m_cnt == m_len - 1) begin
            e.data = DATA_W'(m_acc); e.keep = 64'hF; e.id = inp_id; e.last = inp_last; e.is_csum = 1'b1;
            sb.push_back(e);
            m_acc = 32'h0;
            m_cnt = 0;
          end else begin
            m_cnt++;
          end
        end
        prev_stall = out_valid && !out_ready;
        saved = {out, out_keep, out_id, out_last, out_valid};
      end
    end
  end

  task automatic send(input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k,
                      input logic [ID_W-1:0] id, input logic last);
    logic done = 1'b0;
    inp_data = d; inp_keep = k; inp_id = id; inp_last = last; inp_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clock);
      if (inp_ready) begin
        @(posedge clock);
        #1;
        done = 1'b1;
      end
    end
    inp_valid = 1'b0;
    inp_last = 1'b0;
    checks++;
    assert (done) else begin
      errors++;
      $error("FAIL send_timeout: observed not accepted expected accepted");
    end
  endtask

  task automatic drain();
    logic done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clock);
      if (sb.size() == 0 && !out_valid) done = 1'b1;
    end
    checks++;
    assert (done) else begin
      errors++;
      $error("FAIL drain_timeout: observed %0d pending expected 0", sb.size());
    end
    @(posedge clock);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] lanes(input logic [31:0] v);
    return {16{v}};
  endfunction

  initial begin
    int base;
    logic [DATA_W-1:0] d;
    reset = 1'b0; group_len = 3'd4; inp_valid = 1'b0; inp_last = 1'b0;
    inp_data = '0; inp_keep = '0; inp_id = '0;
    #2;
    chk("rst_out", 640'(out), 640'(0));
    chk("rst_valid", 640'(out_valid), 640'(0));
    chk("rst_keep_id_last", 640'({out_keep, out_id, out_last}), 640'(0));
    chk("rst_inp_ready", 640'(inp_ready), 640'(0));
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    chk("ready_after_rst", 640'(inp_ready), 640'(1));

    // Four-beat group ending with TLAST.
    for (int i = 0; i < 4; i++) send(lanes(32'h1), {KEEP_W{1'b1}}, 6'd5, i == 3);
    drain();
    chk("t1_csum", 640'(last_csum), 640'(32'h40));
    chk("t1_last_id", 640'({last_csum_last, last_csum_id}), 640'({1'b1, 6'd5}));
    chk("t1_count", 640'(csum_cnt), 640'(1));

    // Single TLAST beat closes a short group.
    send(lanes(32'h3), {KEEP_W{1'b1}}, 6'd2, 1'b1);
    drain();
    chk("t2_csum", 640'(last_csum), 640'(32'h30));
    chk("t2_last_id", 640'({last_csum_last, last_csum_id}), 640'({1'b1, 6'd2}));

    // group_len=2: wrap-around, then two more groups without TLAST.
    group_len = 3'd2;
    send(DATA_W'(32'hFFFF_FFFF), {KEEP_W{1'b1}}, 6'd1, 1'b0);
    send(DATA_W'(32'h2), {KEEP_W{1'b1}}, 6'd1, 1'b0);
    drain();
    chk("t3_wrap", 640'(last_csum), 640'(32'h1));
    chk("t3_nolast", 640'(last_csum_last), 640'(0));
    for (int i = 0; i < 4; i++) send(lanes($urandom()), {KEEP_W{1'b1}}, 6'd9, 1'b0);
    drain();
    chk("t3_count", 640'(csum_cnt), 640'(5));

    // Keep masking.
    group_len = 3'd1;
    send(DATA_W'(32'hAABB_CCDD), 64'h1, 6'd3, 1'b0);
    drain();
    chk("t4_keep", 640'(last_csum), 640'(32'hDD));

    // Length clamping: 0 acts as 1, 7 saturates at 4.
    base = csum_cnt;
    group_len = 3'd0;
    send(lanes(32'h5), {KEEP_W{1'b1}}, 6'd4, 1'b0);
    send(lanes(32'h6), {KEEP_W{1'b1}}, 6'd4, 1'b0);
    drain();
    chk("t5_len0", 640'(csum_cnt - base), 640'(2));
    group_len = 3'd7;
    for (int i = 0; i < 4; i++) send(lanes(32'h1), {KEEP_W{1'b1}}, 6'd4, 1'b0);
    drain();
    chk("t5_len7", 640'(csum_cnt - base), 640'(3));

    // group_len change mid-group is ignored until the next group.
    group_len = 3'd4;
    send(lanes(32'h1), {KEEP_W{1'b1}}, 6'd6, 1'b0);
    group_len = 3'd1;
    for (int i = 0; i < 3; i++) send(lanes(32'h1), {KEEP_W{1'b1}}, 6'd6, 1'b0);
    drain();
    chk("t6_midchange", 640'(csum_cnt - base), 640'(4));
    chk("t6_csum", 640'(last_csum), 640'(32'h40));

    // Random backpressure with random data, keep and TLAST.
    bp_en = 1'b1;
    group_len = 3'd3;
    for (int i = 0; i < 12; i++) begin
      for (int l = 0; l < 16; l++) d[l*32 +: 32] = $urandom();
      send(d, {$urandom(), $urandom()}, 6'($urandom_range(0, 63)), $urandom_range(0, 3) == 0);
    end
    bp_en = 1'b0;
    drain();

    // Reset in the middle of a group discards it.
    group_len = 3'd4;
    send(lanes(32'h7), {KEEP_W{1'b1}}, 6'd8, 1'b0);
    send(lanes(32'h7), {KEEP_W{1'b1}}, 6'd8, 1'b0);
    reset = 1'b0;
    #1;
    chk("midrst_outs", 640'({out, out_keep, out_id, out_last, out_valid}), 640'(0));
    chk("midrst_ready", 640'(inp_ready), 640'(0));
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    base = csum_cnt;
    for (int i = 0; i < 4; i++) send(lanes(32'h2), {KEEP_W{1'b1}}, 6'd1, 1'b0);
    drain();
    chk("postrst_csum", 640'(last_csum), 640'(32'h80));
    chk("postrst_count", 640'(csum_cnt - base), 640'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
